// File: rtl/pc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_pkg
// Description : Shared types, constants and helpers for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_pkg;

    typedef enum logic [1:0] {
        PC_RUN  = 2'd0,
        PC_SLOT = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    // Bytes per instruction for sequential fetch.
    localparam int unsigned c_PC_STEP  = 4;
    // Widest address the helpers below support.
    localparam int unsigned c_PC_MAX_W = 64;

    function automatic logic [c_PC_MAX_W-1:0] sext16(input logic [15:0] v);
        return {{(c_PC_MAX_W-16){v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational redirect select and target computation.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int          ADDR_W = 32,
    parameter int unsigned STEP   = c_PC_STEP
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              j_en,
    input  logic [25:0]       j_index,
    input  logic              br_en,
    input  logic              br_taken,
    input  logic [15:0]       br_offset,
    output logic              redirect,
    output logic [ADDR_W-1:0] target
);

    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;

    // J and branch targets are both relative to the delay-slot address.
    assign w_seq       = pc + ADDR_W'(STEP);
    assign w_br_off    = ADDR_W'(sext16(br_offset) << 2);
    assign w_br_target = w_seq + w_br_off;

    generate
        if (ADDR_W > 28) begin : g_j_wide
            assign w_j_target = {w_seq[ADDR_W-1:28], j_index, 2'b00};
        end else begin : g_j_narrow
            assign w_j_target = {j_index, 2'b00};
        end
    endgenerate

    always_comb begin
        redirect = 1'b0;
        target   = '0;
        if (jr_en) begin
            redirect = 1'b1;
            target   = jr_target;
        end else if (j_en) begin
            redirect = 1'b1;
            target   = w_j_target;
        end else if (br_en && br_taken) begin
            redirect = 1'b1;
            target   = w_br_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-PC sequencer with one branch-delay slot, stall, halt
//               detection and sticky misaligned-target error.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_VEC = 32'hBFC0_0000,
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
    parameter int unsigned STEP      = c_PC_STEP
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              jr_en,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              j_en,
    input  logic [25:0]       j_index,
    input  logic              br_en,
    input  logic              br_taken,
    input  logic [15:0]       br_offset,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic              in_slot,
    output logic              halted,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] c_HALT_PC  = ADDR_W'(HALT_ADDR);

    pc_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic              r_in_slot;
    logic              r_halted;
    logic              r_addr_err;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;

    pc_target_calc #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_target_calc (
        .pc        (r_pc),
        .jr_en     (jr_en),
        .jr_target (jr_target),
        .j_en      (j_en),
        .j_index   (j_index),
        .br_en     (br_en),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .redirect  (w_redirect),
        .target    (w_target)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PC_RUN;
            r_pc       <= c_RESET_PC;
            r_target   <= '0;
            r_in_slot  <= 1'b0;
            r_halted   <= 1'b0;
            r_addr_err <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                PC_RUN: begin
                    r_pc <= r_pc + ADDR_W'(STEP);
                    if (w_redirect) begin
                        // Misaligned targets are flagged but still followed, word-aligned.
                        r_target  <= {w_target[ADDR_W-1:2], 2'b00};
                        r_in_slot <= 1'b1;
                        r_state   <= PC_SLOT;
                        if (w_target[1:0] != 2'b00) begin
                            r_addr_err <= 1'b1;
                        end
                    end
                end
                PC_SLOT: begin
                    r_pc      <= r_target;
                    r_in_slot <= 1'b0;
                    if (r_target == c_HALT_PC) begin
                        r_state  <= PC_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= PC_RUN;
                    end
                end
                PC_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= PC_RUN;
                end
            endcase
        end
    end

    assign pc_out   = r_pc;
    assign pc_plus8 = r_pc + ADDR_W'(2 * STEP);
    assign in_slot  = r_in_slot;
    assign halted   = r_halted;
    assign addr_err = r_addr_err;

endmodule
`default_nettype wire
